// File: rtl/dc_pkg.sv
// Shared definitions for the D-cache data-array front end.
// Holds the geometry constants, the core request record and the
// response FSM state type used by the controller, its sub-module and
// its port interface.
package dc_pkg;

  localparam int DEPTH      = 1024;
  localparam int WIDTH      = 256;
  localparam int WORD_W     = 64;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int OFF_WIDTH  = $clog2(WIDTH / WORD_W);
  localparam int STARVE_MAX = 4;
  localparam int BE_W       = WORD_W / 8;
  localparam int WORDS      = WIDTH / WORD_W;
  localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic                  rw;     // 0 = load, 1 = store
    logic [ADDR_WIDTH-1:0] idx;
    logic [OFF_WIDTH-1:0]  off;
    logic [BE_W-1:0]       be;
    logic [WORD_W-1:0]     wdata;
  } dc_core_req_t;

  typedef enum logic {IDLE, RESP} dc_state_e;

endpackage

// File: rtl/dc_data_ctrl_if.sv
// Bundle of every non-clock signal of dc_data_ctrl:
//   core request  : core_req_valid/ready, rw, idx, off, be, wdata
//   core response : core_resp_valid/ready, rdata
//   refill write  : refill_valid/ready, idx, data
//   RAM side      : ram_en, ram_rw, ram_bit_mask, ram_addr, ram_din, ram_qout
// slave  = the controller's view, master = the LSU/refill/RAM environment.
interface dc_data_ctrl_if;
  import dc_pkg::*;

  logic                  core_req_valid;
  logic                  core_req_ready;
  logic                  core_req_rw;
  logic [ADDR_WIDTH-1:0] core_req_idx;
  logic [OFF_WIDTH-1:0]  core_req_off;
  logic [BE_W-1:0]       core_req_be;
  logic [WORD_W-1:0]     core_req_wdata;
  logic                  core_resp_valid;
  logic                  core_resp_ready;
  logic [WORD_W-1:0]     core_resp_rdata;
  logic                  refill_valid;
  logic                  refill_ready;
  logic [ADDR_WIDTH-1:0] refill_idx;
  logic [WIDTH-1:0]      refill_data;
  logic                  ram_en;
  logic                  ram_rw;
  logic [WIDTH-1:0]      ram_bit_mask;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0]      ram_din;
  logic [WIDTH-1:0]      ram_qout;

  modport slave (
    input  core_req_valid, core_req_rw, core_req_idx, core_req_off,
           core_req_be, core_req_wdata, core_resp_ready,
           refill_valid, refill_idx, refill_data, ram_qout,
    output core_req_ready, core_resp_valid, core_resp_rdata, refill_ready,
           ram_en, ram_rw, ram_bit_mask, ram_addr, ram_din
  );

  modport master (
    output core_req_valid, core_req_rw, core_req_idx, core_req_off,
           core_req_be, core_req_wdata, core_resp_ready,
           refill_valid, refill_idx, refill_data, ram_qout,
    input  core_req_ready, core_resp_valid, core_resp_rdata, refill_ready,
           ram_en, ram_rw, ram_bit_mask, ram_addr, ram_din
  );

endinterface

// File: rtl/dc_be_expand.sv
// Turns a word's byte enables into a full-line bit mask.
//   be   in  BE_W       byte enables of the core word
//   off  in  OFF_WIDTH  word slot within the line
//   mask out WIDTH      each enabled byte becomes 8 ones in slot 'off'
module dc_be_expand
  import dc_pkg::*;
(
  input  logic [BE_W-1:0]      be,
  input  logic [OFF_WIDTH-1:0] off,
  output logic [WIDTH-1:0]     mask
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      for (gj = 0; gj < BE_W; gj++) begin : g_byte
        assign mask[gi*WORD_W + gj*8 +: 8] = {8{be[gj] && (off == OFF_WIDTH'(gi))}};
      end
    end
  endgenerate

endmodule

// File: rtl/dc_data_ctrl.sv
// D-cache data-array front end. Arbitrates core word loads/stores
// against full-line refill writes onto the single-port dc_ram and
// returns load words from ram_qout through a valid/ready response.
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  dc_data_ctrl_if.slave (core req/resp, refill, RAM signals)
module dc_data_ctrl
  import dc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  dc_data_ctrl_if.slave  bus
);

  dc_core_req_t          req;
  dc_state_e             state_reg, state_next;
  logic [OFF_WIDTH-1:0]  off_q_reg, off_q_next;
  logic [STARVE_W-1:0]   starve_cnt_reg, starve_cnt_next;
  logic                  core_ok, core_grant, refill_grant, load_grant;
  logic [WIDTH-1:0]      store_mask;

  assign req = '{rw:    bus.core_req_rw,
                 idx:   bus.core_req_idx,
                 off:   bus.core_req_off,
                 be:    bus.core_req_be,
                 wdata: bus.core_req_wdata};

  dc_be_expand u_be_expand (
    .be   (req.be),
    .off  (req.off),
    .mask (store_mask)
  );

  // Loads may only issue once the current response is gone (or leaves
  // this cycle). Stores never touch qout, so they may slip in while a
  // response is stalled.
  always_comb begin
    core_ok      = bus.core_req_valid && !rst &&
                   (state_reg == IDLE || bus.core_resp_ready || req.rw);
    core_grant   = core_ok &&
                   (!bus.refill_valid || starve_cnt_reg == STARVE_W'(STARVE_MAX));
    refill_grant = bus.refill_valid && !rst && !core_grant;
    load_grant   = core_grant && !req.rw;
  end

  // RAM drive straight from the grant; idle leaves ram_en low.
  always_comb begin
    bus.core_req_ready = core_grant;
    bus.refill_ready   = refill_grant;
    bus.ram_en         = 1'b0;
    bus.ram_rw         = 1'b0;
    bus.ram_bit_mask   = '0;
    bus.ram_addr       = req.idx;
    bus.ram_din        = {WORDS{req.wdata}};
    if (refill_grant) begin
      bus.ram_en       = 1'b1;
      bus.ram_rw       = 1'b1;
      bus.ram_bit_mask = '1;
      bus.ram_addr     = bus.refill_idx;
      bus.ram_din      = bus.refill_data;
    end else if (core_grant) begin
      if (req.rw) begin
        // An all-zero byte enable is accepted but costs no RAM cycle.
        bus.ram_en       = |req.be;
        bus.ram_rw       = 1'b1;
        bus.ram_bit_mask = store_mask;
      end else begin
        bus.ram_en = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    off_q_next      = off_q_reg;
    starve_cnt_next = starve_cnt_reg;

    if (load_grant) begin
      state_next = RESP;
      off_q_next = req.off;
    end else if (state_reg == RESP && bus.core_resp_ready) begin
      state_next = IDLE;
    end

    // Only counts refills that actually held off a waiting core request.
    if (core_grant || !bus.core_req_valid) begin
      starve_cnt_next = '0;
    end else if (refill_grant && starve_cnt_reg != STARVE_W'(STARVE_MAX)) begin
      starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
    end

    // qout is held by the RAM until the next read, so it is used unregistered.
    bus.core_resp_valid = (state_reg == RESP) && !rst;
    bus.core_resp_rdata = bus.ram_qout[off_q_reg*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      off_q_reg      <= '0;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      off_q_reg      <= off_q_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

endmodule

// File: tb/tb_dc_data_ctrl.sv
// Bench for dc_data_ctrl with a behavioural dc_ram behind it.
// Stimulus drives the core/refill ports; a monitor keeps a line-level
// model of cache contents, queues expected load words at acceptance and
// compares them when the controller presents a response.
module tb_dc_data_ctrl;
  import dc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dc_data_ctrl_if bus();

  dc_data_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural dc_ram: registered read, qout held until the next read.
  logic [WIDTH-1:0] ram_mem [DEPTH];
  logic [WIDTH-1:0] ram_q;
  always_ff @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_rw)
        ram_mem[bus.ram_addr] <= (ram_mem[bus.ram_addr] & ~bus.ram_bit_mask) |
                                 (bus.ram_din & bus.ram_bit_mask);
      else
        ram_q <= ram_mem[bus.ram_addr];
    end
  end
  assign bus.ram_qout = ram_q;

  typedef struct {
    logic [WORD_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               n_checks = 0;
  int               n_pass   = 0;
  int               cyc      = 0;
  bit               resp_seen = 1'b0;
  bit               rand_done = 1'b0;

  task automatic check(string name, bit ok, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [WIDTH-1:0] rand_line();
    logic [WIDTH-1:0] l;
    for (int w = 0; w < WIDTH/32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  // Monitor / scoreboard: responses first, then this cycle's accepts.
  initial begin : monitor
    bit   core_acc, ref_acc, exp_en;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        resp_seen = 1'b0;
      end else begin
        if (bus.core_resp_valid) begin
          check("resp_expected", exp_q.size() != 0, 1, exp_q.size());
          if (exp_q.size() != 0) begin
            if (!resp_seen) begin
              check("resp_latency", cyc == exp_q[0].cyc + 1, cyc, exp_q[0].cyc + 1);
              resp_seen = 1'b1;
            end
            check("resp_data", bus.core_resp_rdata == exp_q[0].data,
                  bus.core_resp_rdata, exp_q[0].data);
            $display("resp  cyc=%0d data=%h ready=%0d", cyc, bus.core_resp_rdata, bus.core_resp_ready);
            if (bus.core_resp_ready) begin
              void'(exp_q.pop_front());
              resp_seen = 1'b0;
            end
          end
        end

        core_acc = bus.core_req_valid && bus.core_req_ready;
        ref_acc  = bus.refill_valid && bus.refill_ready;
        exp_en   = ref_acc || (core_acc && (!bus.core_req_rw || bus.core_req_be != '0));
        check("one_grant", !(core_acc && ref_acc), {core_acc, ref_acc}, 2'b00);
        check("ram_en", bus.ram_en == exp_en, bus.ram_en, exp_en);

        if (ref_acc) begin
          ref_mem[bus.refill_idx] = bus.refill_data;
          $display("refill cyc=%0d idx=%0d", cyc, bus.refill_idx);
        end
        if (core_acc) begin
          if (bus.core_req_rw) begin
            for (int b = 0; b < BE_W; b++)
              if (bus.core_req_be[b])
                ref_mem[bus.core_req_idx][bus.core_req_off*WORD_W + b*8 +: 8] =
                  bus.core_req_wdata[b*8 +: 8];
            $display("store cyc=%0d idx=%0d off=%0d be=%h", cyc, bus.core_req_idx,
                     bus.core_req_off, bus.core_req_be);
          end else begin
            e.data = ref_mem[bus.core_req_idx][bus.core_req_off*WORD_W +: WORD_W];
            e.cyc  = cyc;
            exp_q.push_back(e);
            $display("load  cyc=%0d idx=%0d off=%0d", cyc, bus.core_req_idx, bus.core_req_off);
          end
        end
      end
    end
  end

  task automatic idle_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted; returns just after the accepting edge.
  task automatic core_send(bit rw, int idx, int off, logic [BE_W-1:0] be, logic [WORD_W-1:0] wdata);
    int n = 0;
    bus.core_req_valid = 1'b1;
    bus.core_req_rw    = rw;
    bus.core_req_idx   = ADDR_WIDTH'(idx);
    bus.core_req_off   = OFF_WIDTH'(off);
    bus.core_req_be    = be;
    bus.core_req_wdata = wdata;
    @(negedge clk);
    while (!bus.core_req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.core_req_ready) check("core_accept_timeout", 1'b0, n, 100);
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    bus.core_req_valid = 1'b0;
  endtask

  task automatic refill_send(int idx, logic [WIDTH-1:0] data);
    int n = 0;
    bus.refill_valid = 1'b1;
    bus.refill_idx   = ADDR_WIDTH'(idx);
    bus.refill_data  = data;
    @(negedge clk);
    while (!bus.refill_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.refill_ready) check("refill_accept_timeout", 1'b0, n, 100);
    @(posedge clk);
    #1;
  endtask

  task automatic refill_idle();
    bus.refill_valid = 1'b0;
  endtask

  initial begin : stim
    int grant_at;
    bus.core_req_valid  = 1'b1;
    bus.core_req_rw     = 1'b0;
    bus.core_req_idx    = '0;
    bus.core_req_off    = '0;
    bus.core_req_be     = '0;
    bus.core_req_wdata  = '0;
    bus.core_resp_ready = 1'b1;
    bus.refill_valid    = 1'b1;
    bus.refill_idx      = '0;
    bus.refill_data     = '0;

    // Reset: requests pending but nothing may be granted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_core_ready",   bus.core_req_ready == 1'b0,  bus.core_req_ready, 0);
    check("rst_refill_ready", bus.refill_ready == 1'b0,    bus.refill_ready, 0);
    check("rst_ram_en",       bus.ram_en == 1'b0,          bus.ram_en, 0);
    check("rst_resp_valid",   bus.core_resp_valid == 1'b0, bus.core_resp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    core_idle();
    refill_idle();

    for (int i = 0; i < 16; i++) refill_send(i, rand_line());
    refill_idle();

    // Refill then word load at offset 2.
    refill_send(5, {32{8'hA5}});
    refill_idle();
    core_send(1'b0, 5, 2, '0, '0);
    core_idle();
    idle_cycles(2);

    // Partial store then reload of the same word.
    core_send(1'b1, 5, 1, 8'h0F, 64'h1122334455667788);
    core_send(1'b0, 5, 1, '0, '0);
    core_idle();
    idle_cycles(2);

    // Stalled response with a store to the same line slipping in.
    bus.core_resp_ready = 1'b0;
    core_send(1'b0, 5, 1, '0, '0);
    core_send(1'b1, 5, 1, 8'hFF, 64'hDEADBEEF0BADF00D);
    core_idle();
    idle_cycles(3);
    bus.core_resp_ready = 1'b1;
    idle_cycles(1);
    core_send(1'b0, 5, 1, '0, '0);
    core_idle();
    idle_cycles(2);

    // Refill stream against a waiting load: core gets the 5th slot.
    bus.core_req_valid = 1'b1;
    bus.core_req_rw    = 1'b0;
    bus.core_req_idx   = ADDR_WIDTH'(5);
    bus.core_req_off   = '0;
    bus.refill_valid   = 1'b1;
    bus.refill_idx     = ADDR_WIDTH'($urandom_range(0, 15));
    bus.refill_data    = rand_line();
    grant_at = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.core_req_ready && grant_at < 0) grant_at = c;
      @(posedge clk);
      #1;
      if (grant_at >= 0) core_idle();
      bus.refill_idx  = ADDR_WIDTH'($urandom_range(0, 15));
      bus.refill_data = rand_line();
    end
    refill_idle();
    core_idle();
    check("starve_grant_cycle", grant_at == 4, grant_at, 4);
    idle_cycles(2);

    // Back-to-back loads.
    core_send(1'b0, 1, $urandom_range(0, 3), '0, '0);
    core_send(1'b0, 2, $urandom_range(0, 3), '0, '0);
    core_send(1'b0, 3, $urandom_range(0, 3), '0, '0);
    core_idle();
    idle_cycles(3);

    // Reset while a response is stalled.
    bus.core_resp_ready = 1'b0;
    core_send(1'b0, 1, 0, '0, '0);
    core_idle();
    rst = 1'b1;
    bus.refill_valid   = 1'b1;
    bus.refill_idx     = ADDR_WIDTH'(2);
    bus.core_req_valid = 1'b1;
    bus.core_req_rw    = 1'b1;
    bus.core_req_be    = 8'hFF;
    @(negedge clk);
    check("rst_mid_ram_en",       bus.ram_en == 1'b0,         bus.ram_en, 0);
    check("rst_mid_core_ready",   bus.core_req_ready == 1'b0, bus.core_req_ready, 0);
    check("rst_mid_refill_ready", bus.refill_ready == 1'b0,   bus.refill_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    refill_idle();
    core_idle();
    @(negedge clk);
    check("post_rst_resp_valid", bus.core_resp_valid == 1'b0, bus.core_resp_valid, 0);
    check("post_rst_ram_en",     bus.ram_en == 1'b0,          bus.ram_en, 0);
    @(posedge clk);
    #1;
    bus.core_resp_ready = 1'b1;
    bus.core_req_valid  = 1'b1;
    bus.core_req_rw     = 1'b1;
    bus.core_req_idx    = ADDR_WIDTH'(2);
    bus.core_req_off    = '0;
    bus.core_req_be     = '0;
    bus.core_req_wdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check("be0_accepted", bus.core_req_ready == 1'b1, bus.core_req_ready, 1);
    check("be0_ram_en",   bus.ram_en == 1'b0,         bus.ram_en, 0);
    @(posedge clk);
    #1;
    core_idle();
    idle_cycles(2);

    // Randomized traffic on lines 0..15.
    fork
      begin
        fork
          begin
            for (int k = 0; k < 120; k++) begin
              if ($urandom_range(0, 2) == 0) begin
                core_idle();
                idle_cycles($urandom_range(0, 2));
              end
              core_send(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3),
                        ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom), {$urandom, $urandom});
            end
            core_idle();
          end
          begin
            for (int k = 0; k < 60; k++) begin
              refill_idle();
              idle_cycles($urandom_range(0, 4));
              refill_send($urandom_range(0, 15), rand_line());
            end
            refill_idle();
          end
        join
        rand_done = 1'b1;
      end
      begin
        for (int k = 0; k < 5000 && !rand_done; k++) begin
          @(posedge clk);
          #1;
          bus.core_resp_ready = ($urandom_range(0, 3) != 0);
        end
        bus.core_resp_ready = 1'b1;
      end
    join
    bus.core_resp_ready = 1'b1;

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle_cycles(1);
    check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
